// File: rtl/exe_operand_stage.sv
// exe_operand_stage
// ID/EXE boundary of the 5-stage ARM pipeline. Holds the decoded instruction,
// resolves MEM/WB forwarding for Rn and Rm, builds Val2 from the shifter
// operand and keeps the NZCV status register.
//
// Flow control: this stage has no valid/ready handshake. freeze=1 holds the
// stage register (the instruction in EXE is not consumed). flush=1 replaces it
// with a bubble, and flush takes priority over freeze. exe_valid marks a real
// instruction. An instruction in EXE completes on an edge where freeze=0.
module exe_operand_stage #(
   parameter int REG_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             freeze,
   input  logic             flush,
   input  logic             id_valid,
   input  logic [3:0]       id_exe_cmd,
   input  logic             id_s,
   input  logic             id_wb_en,
   input  logic             id_mem_r,
   input  logic             id_mem_w,
   input  logic             id_imm,
   input  logic [11:0]      id_shift_operand,
   input  logic [31:0]      id_val_rn,
   input  logic [31:0]      id_val_rm,
   input  logic [REG_W-1:0] id_src1,
   input  logic [REG_W-1:0] id_src2,
   input  logic [REG_W-1:0] id_dest,
   input  logic             mem_wb_en,
   input  logic [REG_W-1:0] mem_dest,
   input  logic [31:0]      mem_alu_res,
   input  logic             wb_wb_en,
   input  logic [REG_W-1:0] wb_dest,
   input  logic [31:0]      wb_value,
   input  logic [3:0]       alu_status,
   output logic [31:0]      val1,
   output logic [31:0]      val2,
   output logic [3:0]       exe_cmd,
   output logic             c_in,
   output logic [3:0]       status,
   output logic             exe_valid,
   output logic             exe_wb_en,
   output logic             exe_mem_r,
   output logic             exe_mem_w,
   output logic [REG_W-1:0] exe_dest,
   output logic [31:0]      exe_store_data
);

   logic             valid_q;
   logic [3:0]       cmd_q;
   logic             s_q;
   logic             wb_en_q;
   logic             mem_r_q;
   logic             mem_w_q;
   logic             imm_q;
   logic [11:0]      so_q;
   logic [31:0]      val_rn_q;
   logic [31:0]      val_rm_q;
   logic [REG_W-1:0] src1_q;
   logic [REG_W-1:0] src2_q;
   logic [REG_W-1:0] dest_q;
   logic [3:0]       status_q;

   logic [31:0]      rn_fwd;
   logic [31:0]      rm_fwd;
   logic [63:0]      rot_imm_wide;
   logic [63:0]      ror_wide;
   logic [4:0]       shift_amt;
   logic [4:0]       rot_amt;

   // Stage register: reset > flush > freeze > load.
   always_ff @(posedge clk) begin
      if (!rst || flush) begin
         valid_q  <= 1'b0;
         cmd_q    <= 4'd0;
         s_q      <= 1'b0;
         wb_en_q  <= 1'b0;
         mem_r_q  <= 1'b0;
         mem_w_q  <= 1'b0;
         imm_q    <= 1'b0;
         so_q     <= 12'd0;
         val_rn_q <= 32'd0;
         val_rm_q <= 32'd0;
         src1_q   <= '0;
         src2_q   <= '0;
         dest_q   <= '0;
      end else if (!freeze) begin
         valid_q  <= id_valid;
         cmd_q    <= id_exe_cmd;
         s_q      <= id_s;
         wb_en_q  <= id_wb_en;
         mem_r_q  <= id_mem_r;
         mem_w_q  <= id_mem_w;
         imm_q    <= id_imm;
         so_q     <= id_shift_operand;
         val_rn_q <= id_val_rn;
         val_rm_q <= id_val_rm;
         src1_q   <= id_src1;
         src2_q   <= id_src2;
         dest_q   <= id_dest;
      end
   end

   // Status register: an S-instruction writes NZCV on the edge it leaves EXE.
   always_ff @(posedge clk) begin
      if (!rst) begin
         status_q <= 4'd0;
      end else if (valid_q && s_q && !freeze) begin
         status_q <= alu_status;
      end
   end

   // Forwarding: MEM result is newer than WB, so it wins.
   always_comb begin
      rn_fwd = val_rn_q;
      if (mem_wb_en && (mem_dest == src1_q)) begin
         rn_fwd = mem_alu_res;
      end else if (wb_wb_en && (wb_dest == src1_q)) begin
         rn_fwd = wb_value;
      end
      rm_fwd = val_rm_q;
      if (mem_wb_en && (mem_dest == src2_q)) begin
         rm_fwd = mem_alu_res;
      end else if (wb_wb_en && (wb_dest == src2_q)) begin
         rm_fwd = wb_value;
      end
   end

   // Val2 generation: memory offset, rotated immediate, or shifted Rm.
   always_comb begin
      shift_amt    = so_q[11:7];
      rot_amt      = {so_q[11:8], 1'b0};
      rot_imm_wide = {24'd0, so_q[7:0], 24'd0, so_q[7:0]} >> rot_amt;
      ror_wide     = {rm_fwd, rm_fwd} >> shift_amt;
      val2         = rm_fwd;
      if (mem_r_q || mem_w_q) begin
         val2 = {20'd0, so_q};
      end else if (imm_q) begin
         val2 = rot_imm_wide[31:0];
      end else begin
         case (so_q[6:5])
            2'b00:   val2 = rm_fwd << shift_amt;
            2'b01:   val2 = rm_fwd >> shift_amt;
            2'b10:   val2 = $unsigned($signed(rm_fwd) >>> shift_amt);
            default: val2 = ror_wide[31:0];
         endcase
      end
   end

   assign val1           = rn_fwd;
   assign exe_store_data = rm_fwd;
   assign exe_cmd        = valid_q ? cmd_q : 4'd0;
   assign status         = status_q;
   assign c_in           = status_q[1];
   assign exe_valid      = valid_q;
   assign exe_wb_en      = wb_en_q;
   assign exe_mem_r      = mem_r_q;
   assign exe_mem_w      = mem_w_q;
   assign exe_dest       = dest_q;

endmodule

// File: tb/tb_exe_operand_stage.sv
// Directed testbench for exe_operand_stage.
module tb_exe_operand_stage;

   logic        clk;
   logic        rst;
   logic        freeze;
   logic        flush;
   logic        id_valid;
   logic [3:0]  id_exe_cmd;
   logic        id_s;
   logic        id_wb_en;
   logic        id_mem_r;
   logic        id_mem_w;
   logic        id_imm;
   logic [11:0] id_shift_operand;
   logic [31:0] id_val_rn;
   logic [31:0] id_val_rm;
   logic [3:0]  id_src1;
   logic [3:0]  id_src2;
   logic [3:0]  id_dest;
   logic        mem_wb_en;
   logic [3:0]  mem_dest;
   logic [31:0] mem_alu_res;
   logic        wb_wb_en;
   logic [3:0]  wb_dest;
   logic [31:0] wb_value;
   logic [3:0]  alu_status;
   logic [31:0] val1;
   logic [31:0] val2;
   logic [3:0]  exe_cmd;
   logic        c_in;
   logic [3:0]  status;
   logic        exe_valid;
   logic        exe_wb_en;
   logic        exe_mem_r;
   logic        exe_mem_w;
   logic [3:0]  exe_dest;
   logic [31:0] exe_store_data;

   int checks = 0;
   int errors = 0;

   exe_operand_stage #(.REG_W(4)) dut (
      .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
      .id_valid(id_valid), .id_exe_cmd(id_exe_cmd), .id_s(id_s),
      .id_wb_en(id_wb_en), .id_mem_r(id_mem_r), .id_mem_w(id_mem_w),
      .id_imm(id_imm), .id_shift_operand(id_shift_operand),
      .id_val_rn(id_val_rn), .id_val_rm(id_val_rm),
      .id_src1(id_src1), .id_src2(id_src2), .id_dest(id_dest),
      .mem_wb_en(mem_wb_en), .mem_dest(mem_dest), .mem_alu_res(mem_alu_res),
      .wb_wb_en(wb_wb_en), .wb_dest(wb_dest), .wb_value(wb_value),
      .alu_status(alu_status),
      .val1(val1), .val2(val2), .exe_cmd(exe_cmd), .c_in(c_in),
      .status(status), .exe_valid(exe_valid), .exe_wb_en(exe_wb_en),
      .exe_mem_r(exe_mem_r), .exe_mem_w(exe_mem_w), .exe_dest(exe_dest),
      .exe_store_data(exe_store_data)
   );

   // Clock and watchdog
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   // Advance one edge; inputs are driven and outputs sampled 1 time unit after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_idle();
      freeze = 0; flush = 0;
      id_valid = 0; id_exe_cmd = 0; id_s = 0; id_wb_en = 0;
      id_mem_r = 0; id_mem_w = 0; id_imm = 0; id_shift_operand = 0;
      id_val_rn = 0; id_val_rm = 0; id_src1 = 0; id_src2 = 0; id_dest = 0;
      mem_wb_en = 0; mem_dest = 0; mem_alu_res = 0;
      wb_wb_en = 0; wb_dest = 0; wb_value = 0; alu_status = 0;
   endtask

   task automatic test_reset();
      drive_idle();
      rst = 0;
      tick(); tick();
      rst = 1;
      // S-instruction in EXE with live ALU flags; reset must discard it.
      id_valid = 1; id_exe_cmd = 4'd4; id_s = 1; id_wb_en = 1; id_dest = 4'd9;
      alu_status = 4'b1111;
      tick();
      rst = 0;
      id_exe_cmd = 4'd2; id_s = 0;
      tick();
      checks++; if (status !== 4'b0000) begin errors++; $display("FAIL reset_status got=%b exp=%b", status, 4'b0000); end
      checks++; if (exe_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=%b", exe_valid, 1'b0); end
      checks++; if (exe_cmd !== 4'd0) begin errors++; $display("FAIL reset_cmd got=%0d exp=%0d", exe_cmd, 0); end
      checks++; if (c_in !== 1'b0) begin errors++; $display("FAIL reset_c_in got=%b exp=%b", c_in, 1'b0); end
      checks++; if (exe_wb_en !== 1'b0) begin errors++; $display("FAIL reset_wb_en got=%b exp=%b", exe_wb_en, 1'b0); end
      rst = 1;
      alu_status = 4'b0000;
      tick();
      checks++; if (exe_valid !== 1'b1) begin errors++; $display("FAIL post_reset_valid got=%b exp=%b", exe_valid, 1'b1); end
      checks++; if (exe_cmd !== 4'd2) begin errors++; $display("FAIL post_reset_cmd got=%0d exp=%0d", exe_cmd, 2); end
      checks++; if (exe_dest !== 4'd9) begin errors++; $display("FAIL post_reset_dest got=%0d exp=%0d", exe_dest, 9); end
      drive_idle();
      tick();
   endtask

   task automatic test_immediate();
      drive_idle();
      id_valid = 1; id_exe_cmd = 4'd1; id_imm = 1; id_shift_operand = 12'h4FF;
      tick();
      checks++; if (val2 !== 32'hFF000000) begin errors++; $display("FAIL imm_rot8 got=%h exp=%h", val2, 32'hFF000000); end
      id_shift_operand = 12'h0AB;
      tick();
      checks++; if (val2 !== 32'h000000AB) begin errors++; $display("FAIL imm_rot0 got=%h exp=%h", val2, 32'h000000AB); end
      id_imm = 0; id_mem_r = 1; id_shift_operand = 12'hFFF; id_val_rm = 32'h12345678;
      tick();
      checks++; if (val2 !== 32'h00000FFF) begin errors++; $display("FAIL mem_offset got=%h exp=%h", val2, 32'h00000FFF); end
      checks++; if (exe_mem_r !== 1'b1) begin errors++; $display("FAIL mem_r got=%b exp=%b", exe_mem_r, 1'b1); end
   endtask

   task automatic test_shift();
      drive_idle();
      id_valid = 1; id_exe_cmd = 4'd1; id_val_rm = 32'h80000001; id_src2 = 4'd5;
      id_shift_operand = 12'h200;
      tick();
      checks++; if (val2 !== 32'h00000010) begin errors++; $display("FAIL lsl4 got=%h exp=%h", val2, 32'h00000010); end
      checks++; if (exe_store_data !== 32'h80000001) begin errors++; $display("FAIL store_data got=%h exp=%h", exe_store_data, 32'h80000001); end
      id_shift_operand = 12'h220;
      tick();
      checks++; if (val2 !== 32'h08000000) begin errors++; $display("FAIL lsr4 got=%h exp=%h", val2, 32'h08000000); end
      id_shift_operand = 12'h240;
      tick();
      checks++; if (val2 !== 32'hF8000000) begin errors++; $display("FAIL asr4 got=%h exp=%h", val2, 32'hF8000000); end
      id_shift_operand = 12'h260;
      tick();
      checks++; if (val2 !== 32'h18000000) begin errors++; $display("FAIL ror4 got=%h exp=%h", val2, 32'h18000000); end
      id_shift_operand = 12'h060;
      tick();
      checks++; if (val2 !== 32'h80000001) begin errors++; $display("FAIL shift0 got=%h exp=%h", val2, 32'h80000001); end
      // Forwarded Rm goes through the shifter: MEM supplies R5 = 1, LSL 4.
      id_shift_operand = 12'h200;
      tick();
      mem_wb_en = 1; mem_dest = 4'd5; mem_alu_res = 32'h00000001;
      #1;
      checks++; if (val2 !== 32'h00000010) begin errors++; $display("FAIL fwd_shift got=%h exp=%h", val2, 32'h00000010); end
      checks++; if (exe_store_data !== 32'h00000001) begin errors++; $display("FAIL fwd_store got=%h exp=%h", exe_store_data, 32'h00000001); end
   endtask

   task automatic test_forwarding();
      drive_idle();
      id_valid = 1; id_exe_cmd = 4'd2; id_src1 = 4'd3; id_val_rn = 32'h00000033;
      tick();
      mem_wb_en = 1; mem_dest = 4'd3; mem_alu_res = 32'h11;
      wb_wb_en = 1; wb_dest = 4'd3; wb_value = 32'h22;
      #1;
      checks++; if (val1 !== 32'h11) begin errors++; $display("FAIL fwd_mem_wins got=%h exp=%h", val1, 32'h11); end
      mem_wb_en = 0;
      #1;
      checks++; if (val1 !== 32'h22) begin errors++; $display("FAIL fwd_wb got=%h exp=%h", val1, 32'h22); end
      wb_wb_en = 0;
      #1;
      checks++; if (val1 !== 32'h33) begin errors++; $display("FAIL fwd_none got=%h exp=%h", val1, 32'h33); end
      // MEM enabled but a different destination must not forward.
      mem_wb_en = 1; mem_dest = 4'd4;
      #1;
      checks++; if (val1 !== 32'h33) begin errors++; $display("FAIL fwd_mismatch got=%h exp=%h", val1, 32'h33); end
      // R15 forwards like any other index.
      id_src1 = 4'd15; mem_dest = 4'd15; mem_alu_res = 32'hCAFE0000;
      tick();
      checks++; if (val1 !== 32'hCAFE0000) begin errors++; $display("FAIL fwd_r15 got=%h exp=%h", val1, 32'hCAFE0000); end
   endtask

   task automatic test_back_to_back();
      drive_idle();
      id_valid = 1; id_exe_cmd = 4'd4; id_s = 1;
      tick();
      // SUBS in EXE; ADC waits in ID.
      alu_status = 4'b0010;
      id_exe_cmd = 4'd3; id_s = 0;
      tick();
      checks++; if (status !== 4'b0010) begin errors++; $display("FAIL subs_status got=%b exp=%b", status, 4'b0010); end
      checks++; if (c_in !== 1'b1) begin errors++; $display("FAIL adc_c_in got=%b exp=%b", c_in, 1'b1); end
      checks++; if (exe_cmd !== 4'd3) begin errors++; $display("FAIL adc_cmd got=%0d exp=%0d", exe_cmd, 3); end
      // Non-S instruction in EXE must not write status.
      alu_status = 4'b1111;
      id_valid = 0; id_exe_cmd = 4'd0;
      tick();
      checks++; if (status !== 4'b0010) begin errors++; $display("FAIL non_s_hold got=%b exp=%b", status, 4'b0010); end
      checks++; if (exe_cmd !== 4'd0) begin errors++; $display("FAIL bubble_cmd got=%0d exp=%0d", exe_cmd, 0); end
   endtask

   task automatic test_stall_flush();
      drive_idle();
      id_valid = 1; id_exe_cmd = 4'd4; id_s = 1; id_wb_en = 1; id_dest = 4'd7;
      alu_status = 4'b1000;
      tick();
      freeze = 1;
      id_exe_cmd = 4'd6; id_dest = 4'd2;
      for (int i = 0; i < 2; i++) begin
         tick();
         checks++; if (exe_cmd !== 4'd4) begin errors++; $display("FAIL freeze_cmd got=%0d exp=%0d", exe_cmd, 4); end
         checks++; if (exe_dest !== 4'd7) begin errors++; $display("FAIL freeze_dest got=%0d exp=%0d", exe_dest, 7); end
         checks++; if (status !== 4'b0010) begin errors++; $display("FAIL freeze_status got=%b exp=%b", status, 4'b0010); end
      end
      freeze = 0;
      tick();
      checks++; if (status !== 4'b1000) begin errors++; $display("FAIL release_status got=%b exp=%b", status, 4'b1000); end
      checks++; if (exe_cmd !== 4'd6) begin errors++; $display("FAIL release_cmd got=%0d exp=%0d", exe_cmd, 6); end
      // ANDS now in EXE; flush and freeze together: flush wins, freeze blocks status.
      alu_status = 4'b0101;
      flush = 1; freeze = 1;
      tick();
      checks++; if (exe_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got=%b exp=%b", exe_valid, 1'b0); end
      checks++; if (exe_wb_en !== 1'b0) begin errors++; $display("FAIL flush_wb_en got=%b exp=%b", exe_wb_en, 1'b0); end
      checks++; if (status !== 4'b1000) begin errors++; $display("FAIL flush_status got=%b exp=%b", status, 4'b1000); end
      checks++; if (exe_cmd !== 4'd0) begin errors++; $display("FAIL flush_cmd got=%0d exp=%0d", exe_cmd, 0); end
      flush = 0; freeze = 0; id_valid = 0; id_s = 0;
      tick();
      checks++; if (status !== 4'b1000) begin errors++; $display("FAIL bubble_status got=%b exp=%b", status, 4'b1000); end
   endtask

   initial begin
      rst = 0;
      drive_idle();
      test_reset();
      test_immediate();
      test_shift();
      test_forwarding();
      test_back_to_back();
      test_stall_flush();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
